pwm_ramp_ctrl: RTL and testbench
================================

PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE, default 1, meaning clocks per PWM counter tick; legal range 1..65535.
REQ-002 SHALL have parameter DWELL_PERIODS, default 4, meaning full PWM periods held at each ramp step; legal range 1..255.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset, synchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1, meaning a speed request is presented.
REQ-006 SHALL have port req_enable, input, 1, meaning the requested run/stop; 0 means stop.
REQ-007 SHALL have port req_speed, input, 3, meaning the requested duty level 0..7, in eighths.
REQ-008 SHALL have port req_ready, output, 1, meaning the block accepts a request this cycle.
REQ-009 SHALL have port pwm_out, output, 1, meaning the PWM drive.
REQ-010 SHALL have port cur_speed, output, 3, meaning the duty level currently applied.
REQ-011 SHALL have port busy, output, 1, meaning a ramp is in progress.
REQ-012 SHALL have port active, output, 1, meaning the block is not in IDLE.

Function
REQ-013 SHALL implement a 16-bit prescaler that pulses tick when it reaches PRESCALE-1 and then wraps to 0.
- It SHALL run freely in every state.
REQ-014 SHALL implement a 3-bit period counter cnt.
- cnt SHALL advance on each tick and wrap from 7 to 0.
- period_end SHALL be the condition tick AND cnt==7.
REQ-015 SHALL register pwm_out each clock as (state!=IDLE) AND (cnt < cur_speed).
- This gives a one-clock latency.
- Level 7 SHALL yield 7/8 duty.
- Level 0 SHALL yield a constant 0.
REQ-016 SHALL implement FSM states IDLE, RAMP and RUN.
REQ-017 SHALL drive req_ready=1 in IDLE and RUN, and req_ready=0 in RAMP.
REQ-018 SHALL accept a request only when req_valid AND req_ready.
- On acceptance, target SHALL be loaded with req_enable ? req_speed : 0.
- req_valid while req_ready=0 SHALL be ignored, with no state change.
REQ-019 SHALL handle an accepted request with target != cur_speed as follows:
- enter RAMP;
- clear the dwell counter;
- set busy=1 on the next cycle.
REQ-020 SHALL handle an accepted request with target == cur_speed as follows:
- the state SHALL stay unchanged;
- this includes target 0 while in IDLE.
REQ-021 SHALL, in RAMP, increment the dwell counter on each period_end.
- When dwell==DWELL_PERIODS-1 at a period_end, cur_speed SHALL step by one toward target.
- At the same period_end, dwell SHALL clear.
REQ-022 SHALL change cur_speed only at a period_end, so that every PWM period is glitch-free.
REQ-023 SHALL, on the step that makes cur_speed equal target, go to RUN if target!=0 and to IDLE if target==0.
- busy SHALL fall in the same cycle.
REQ-024 SHALL hold cur_speed constant and busy=0 in RUN.
REQ-025 SHALL drive active=(state!=IDLE).
REQ-026 SHALL keep the dwell count of a new ramp starting at 0 when a request is accepted in the same cycle as a period_end.

Reset
REQ-027 SHALL, while rst_n=0 at a clock edge, set the following values:
- state IDLE;
- cur_speed 0, target 0;
- prescaler 0, cnt 0, dwell 0;
- pwm_out 0, busy 0, active 0, req_ready 1.
REQ-028 SHALL abandon any ramp on reset without completing it.

Verification (PRESCALE=1, DWELL_PERIODS=2, period = 8 clocks)
REQ-029 SHALL cover this reset scenario: rst_n=0 for 3 clocks with req_valid=1 -> all reset values of REQ-027 hold, and no request is taken.
REQ-030 SHALL cover this ramp-up scenario: IDLE, request enable=1 speed=3 -> behaviour is as follows:
- busy and active are 1 next cycle;
- cur_speed steps 1, 2, 3, 16 clocks apart, at period boundaries;
- RUN is entered and busy=0;
- pwm_out is high 3 of every 8 clocks.
REQ-031 SHALL cover this ramp-down scenario: RUN at 5, request enable=0 -> behaviour is as follows:
- cur_speed goes 4, 3, 2, 1, 0, 16 clocks apart;
- the block returns to IDLE;
- pwm_out and active are 0.
REQ-032 SHALL cover this no-op scenario: RUN at 7, request enable=1 speed=7 -> busy stays 0 and pwm_out stays high 7 of every 8 clocks.
REQ-033 SHALL cover this busy scenario: during the ramp 0->6, a request of speed=1 -> req_ready=0, the request is ignored, and the ramp completes at 6.
REQ-034 SHALL cover this mid-ramp reset scenario: rst_n=0 for one clock at cur_speed=2 during the ramp to 5 -> reset values appear on the next cycle, and pwm_out stays 0 until a new request.

Source files
------------

// File: rtl/pwm_ramp_ctrl.sv
// PWM generator whose duty level ramps one eighth at a time toward a requested
// speed, holding each step for a fixed number of PWM periods.
module pwm_ramp_ctrl #(
  parameter int PRESCALE      = 1,
  parameter int DWELL_PERIODS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic       req_enable,
  input  logic [2:0] req_speed,
  output logic       req_ready,
  output logic       pwm_out,
  output logic [2:0] cur_speed,
  output logic       busy,
  output logic       active
);

  typedef enum logic [1:0] {IDLE, RAMP, RUN} state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] presc;
  logic        tick;
  logic [2:0]  cnt;
  logic        period_end;
  logic [7:0]  dwell;
  logic [2:0]  target;
  logic [2:0]  req_target;
  logic [2:0]  step_speed;
  logic        accept;
  logic        step;
  logic        arrive;

  assign tick       = (presc == 16'(PRESCALE - 1));
  assign period_end = tick && (cnt == 3'd7);
  assign req_target = req_enable ? req_speed : 3'd0;
  assign accept     = req_valid && req_ready;
  assign step       = (state == RAMP) && period_end && (dwell == 8'(DWELL_PERIODS - 1));
  assign step_speed = (target > cur_speed) ? cur_speed + 3'd1 : cur_speed - 3'd1;
  assign arrive     = step && (step_speed == target);

  // Prescaler and period counter run in every state so PWM phase never jumps.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc <= 16'd0;
      cnt   <= 3'd0;
    end else begin
      presc <= tick ? 16'd0 : presc + 16'd1;
      if (tick) cnt <= cnt + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, RUN: if (accept && (req_target != cur_speed)) state_next = RAMP;
      RAMP:      if (arrive) state_next = (target == 3'd0) ? IDLE : RUN;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state != RAMP);
    busy      = (state == RAMP);
    active    = (state != IDLE);
  end

  // Speed only moves at a period_end, so each PWM period uses a single level.
  // Acceptance and ramping are exclusive because req_ready is low in RAMP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_speed <= 3'd0;
      target    <= 3'd0;
      dwell     <= 8'd0;
      pwm_out   <= 1'b0;
    end else begin
      pwm_out <= (state != IDLE) && (cnt < cur_speed);
      if (accept) begin
        target <= req_target;
        dwell  <= 8'd0;
      end else if ((state == RAMP) && period_end) begin
        if (step) begin
          dwell     <= 8'd0;
          cur_speed <= step_speed;
        end else begin
          dwell <= dwell + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl with PRESCALE=1, DWELL_PERIODS=2
// (8-clock PWM period, speed steps 16 clocks apart).
module tb_pwm_ramp_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_enable;
  logic [2:0] req_speed;
  logic       req_ready;
  logic       pwm_out;
  logic [2:0] cur_speed;
  logic       busy;
  logic       active;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned phase    = 0;

  typedef struct {
    bit       en;
    bit [2:0] spd;
    bit [2:0] exp_speed;
    bit       exp_active;
    int       exp_steps;
  } vec_t;

  vec_t vecs[7];
  vec_t sb_q[$];

  pwm_ramp_ctrl #(.PRESCALE(1), .DWELL_PERIODS(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_enable(req_enable),
    .req_speed (req_speed),
    .req_ready (req_ready),
    .pwm_out   (pwm_out),
    .cur_speed (cur_speed),
    .busy      (busy),
    .active    (active)
  );

  always #5 clk = ~clk;

  // Clocks since reset release; modulo 8 it equals the PWM period position.
  always @(posedge clk) phase <= rst_n ? phase + 1 : 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic measure_duty(input string name, input int exp_high);
    int hi = 0;
    repeat (8) begin
      @(negedge clk);
      hi += int'(pwm_out);
    end
    check({name, " duty"}, hi, exp_high);
  endtask

  // Watch a ramp from the current negedge until busy drops; checks each step.
  task automatic follow_ramp(input string name, input int tgt, input int min_cycles,
                             input logic [2:0] start, output int steps, output bit done,
                             output bit busy_seen);
    int         since = 0;
    logic [2:0] prev  = start;
    steps     = 0;
    done      = 1'b0;
    busy_seen = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      if (busy) busy_seen = 1'b1;
      if (cur_speed !== prev) begin
        steps++;
        check({name, " step dir"}, int'(cur_speed), (prev < tgt) ? prev + 1 : prev - 1);
        check({name, " step boundary"}, int'(phase % 8), 0);
        if (steps > 1) check({name, " step spacing"}, since, 16);
        else           check({name, " first step within 16"}, int'(since <= 16), 1);
        since = 0;
        prev  = cur_speed;
      end
      if (!busy && c >= min_cycles) done = 1'b1;
      else begin
        @(negedge clk);
        since++;
      end
    end
  endtask

  task automatic apply_vec(input vec_t v, input string name);
    vec_t       e;
    int         steps;
    bit         done;
    bit         busy_seen;
    logic [2:0] start;
    @(negedge clk);
    check({name, " ready"}, int'(req_ready), 1);
    start      = cur_speed;
    req_valid  = 1'b1;
    req_enable = v.en;
    req_speed  = v.spd;
    sb_q.push_back(v);
    @(negedge clk);
    req_valid = 1'b0;
    check({name, " busy next"}, int'(busy), int'(v.exp_steps != 0));
    follow_ramp(name, v.en ? int'(v.spd) : 0, (v.exp_steps == 0) ? 16 : 0,
                start, steps, done, busy_seen);
    check({name, " completes"}, int'(done), 1);
    e = sb_q.pop_front();
    if (e.exp_steps == 0) check({name, " busy stays 0"}, int'(busy_seen), 0);
    check({name, " final speed"}, int'(cur_speed), int'(e.exp_speed));
    check({name, " active"}, int'(active), int'(e.exp_active));
    check({name, " step count"}, steps, e.exp_steps);
    check({name, " busy after"}, int'(busy), 0);
    measure_duty(name, e.exp_active ? int'(e.exp_speed) : 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       v;
    int         steps;
    bit         done;
    bit         busy_seen;
    bit         went_down;
    logic [2:0] last;
    int         pwm_hi;
    int         act_hi;

    //            en    spd   exp_speed exp_active steps
    vecs[0] = '{1'b1, 3'd3, 3'd3, 1'b1, 3};  // ramp up from IDLE
    vecs[1] = '{1'b1, 3'd5, 3'd5, 1'b1, 2};
    vecs[2] = '{1'b0, 3'd5, 3'd0, 1'b0, 5};  // stop: ramp down to IDLE
    vecs[3] = '{1'b1, 3'd7, 3'd7, 1'b1, 7};
    vecs[4] = '{1'b1, 3'd7, 3'd7, 1'b1, 0};  // no-op in RUN at 7
    vecs[5] = '{1'b1, 3'd0, 3'd0, 1'b0, 7};  // enabled at speed 0 counts as stop
    vecs[6] = '{1'b0, 3'd0, 3'd0, 1'b0, 0};  // target 0 in IDLE

    // Reset held three clocks with a request presented.
    rst_n      = 1'b0;
    req_valid  = 1'b1;
    req_enable = 1'b1;
    req_speed  = 3'd5;
    repeat (3) @(negedge clk);
    check("reset cur_speed", int'(cur_speed), 0);
    check("reset pwm_out", int'(pwm_out), 0);
    check("reset busy", int'(busy), 0);
    check("reset active", int'(active), 0);
    check("reset req_ready", int'(req_ready), 1);
    rst_n     = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    check("reset no request taken", int'(active), 0);

    for (int i = 0; i < 7; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Request during a ramp is ignored and the ramp finishes at its target.
    @(negedge clk);
    req_valid  = 1'b1;
    req_enable = 1'b1;
    req_speed  = 3'd6;
    v          = '{1'b1, 3'd6, 3'd6, 1'b1, 6};
    sb_q.push_back(v);
    @(negedge clk);
    req_speed = 3'd1;
    check("busy req_ready", int'(req_ready), 0);
    check("busy flag", int'(busy), 1);
    went_down = 1'b0;
    last      = cur_speed;
    repeat (40) begin
      @(negedge clk);
      if (cur_speed < last) went_down = 1'b1;
      last = cur_speed;
    end
    check("busy ignored request", int'(went_down), 0);
    req_valid = 1'b0;
    follow_ramp("busy", 6, 0, last, steps, done, busy_seen);
    check("busy completes", int'(done), 1);
    v = sb_q.pop_front();
    check("busy final speed", int'(cur_speed), int'(v.exp_speed));
    check("busy active", int'(active), int'(v.exp_active));
    check("busy ready after", int'(req_ready), 1);
    measure_duty("busy", 6);

    apply_vec('{1'b0, 3'd0, 3'd0, 1'b0, 6}, "back to idle");

    // Reset in the middle of a ramp toward 5.
    @(negedge clk);
    req_valid  = 1'b1;
    req_enable = 1'b1;
    req_speed  = 3'd5;
    @(negedge clk);
    req_valid = 1'b0;
    done      = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      if (cur_speed == 3'd2) done = 1'b1;
      else @(negedge clk);
    end
    check("midreset reached 2", int'(done), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset cur_speed", int'(cur_speed), 0);
    check("midreset busy", int'(busy), 0);
    check("midreset active", int'(active), 0);
    check("midreset req_ready", int'(req_ready), 1);
    check("midreset pwm_out", int'(pwm_out), 0);
    pwm_hi = 0;
    act_hi = 0;
    repeat (24) begin
      @(negedge clk);
      pwm_hi += int'(pwm_out);
      act_hi += int'(active);
    end
    check("midreset pwm stays 0", pwm_hi, 0);
    check("midreset stays idle", act_hi, 0);

    apply_vec('{1'b1, 3'd2, 3'd2, 1'b1, 2}, "after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
